// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: character width, default baud divider, framer states.
// DATA_W is also used by the upstream parity generator.
package rs232_pkg;

  localparam int DATA_W               = 7;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Counter width for a divider of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs232_tx_framer_if.sv
// Upstream character handshake into the framer.
// valid/ready: a transfer happens on a rising edge where data_valid && data_ready;
// data and parity_bit must be stable and aligned while data_valid is high.
interface rs232_tx_framer_if;

  logic [rs232_pkg::DATA_W-1:0] data;
  logic                         parity_bit;
  logic                         data_valid;
  logic                         data_ready;

  modport master (output data, output parity_bit, output data_valid, input data_ready);
  modport slave  (input data, input parity_bit, input data_valid, output data_ready);

endinterface

// File: rtl/rs232_baud_tick.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous restart.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rs232_tx_framer.sv
// RS-232 transmit framer: start bit, 7 data bits LSB first, supplied parity, 1 or 2 stop bits.
// tx is a flop loaded from the next-state decode, so the line never glitches.
module rs232_tx_framer
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rs232_tx_framer_if.slave     up,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output state_t               state_dbg
);

  state_t            state, state_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [DATA_W-1:0] hold_data;
  logic              hold_par;
  logic              tick;
  logic              accept;
  logic              tx_n;

  assign up.data_ready = (state == ST_IDLE);
  assign accept        = up.data_valid && up.data_ready;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  // Any state change realigns the bit period to the first cycle of the new state.
  rs232_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state_n != state),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      tx        <= 1'b1;
      hold_data <= '0;
      hold_par  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      if (accept) begin
        hold_data <= up.data;
        hold_par  <= up.parity_bit;
      end
    end
  end

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    frame_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n   = ST_START;
          bit_idx_n = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == 3'(DATA_W - 1)) begin
            state_n   = ST_PARITY;
            bit_idx_n = '0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n   = ST_STOP;
          bit_idx_n = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            state_n    = ST_IDLE;
            bit_idx_n  = '0;
            frame_done = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_n   = ST_IDLE;
        bit_idx_n = '0;
      end
    endcase
  end

  // Line level for the cycle after this edge; the data bit comes from the captured character.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      ST_IDLE:   tx_n = 1'b1;
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = hold_data[bit_idx_n];
      ST_PARITY: tx_n = hold_par;
      ST_STOP:   tx_n = 1'b1;
      default:   tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rs232_tx_framer.sv
// Bench for rs232_tx_framer: two instances (4 clk/bit 1 stop, 1 clk/bit 2 stops) checked
// cycle by cycle against a line-level model built from the frame definition.
module tb_rs232_tx_framer;
  import rs232_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs232_tx_framer_if if_a ();
  rs232_tx_framer_if if_b ();

  logic   tx_a, busy_a, fd_a;
  logic   tx_b, busy_b, fd_b;
  state_t st_a, st_b;

  rs232_tx_framer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .up(if_a.slave),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .state_dbg(st_a)
  );

  rs232_tx_framer #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .up(if_b.slave),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .state_dbg(st_b)
  );

  int n_pass   = 0;
  int n_checks = 0;

  logic [0:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic get_tx(input int w);    return (w != 0) ? tx_b : tx_a;   endfunction
  function automatic logic get_busy(input int w);  return (w != 0) ? busy_b : busy_a; endfunction
  function automatic logic get_fd(input int w);    return (w != 0) ? fd_b : fd_a;   endfunction
  function automatic logic get_ready(input int w);
    return (w != 0) ? if_b.data_ready : if_a.data_ready;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int w, input logic v, input logic [6:0] d, input logic p);
    if (w == 0) begin
      if_a.data_valid = v; if_a.data = d; if_a.parity_bit = p;
    end else begin
      if_b.data_valid = v; if_b.data = d; if_b.parity_bit = p;
    end
  endtask

  // Expected line sequence: start, data LSB first, parity, stop bits; each bit n cycles.
  task automatic build_frame(input logic [6:0] d, input logic p, input int n, input int sb);
    exp_q.delete();
    for (int c = 0; c < n; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++)
      for (int c = 0; c < n; c++) exp_q.push_back(d[i]);
    for (int c = 0; c < n; c++) exp_q.push_back(p);
    for (int c = 0; c < n * sb; c++) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge; offers d/p, then checks every frame cycle. After the first
  // frame cycle the upstream presents nd/np (valid kept high when keep is set).
  task automatic run_frame(input int w, input logic [6:0] d, input logic p,
                           input bit keep, input logic [6:0] nd, input logic np);
    int    budget;
    int    len;
    logic  e;
    budget = 0;
    while (!get_ready(w) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("ready_before_accept", get_ready(w), 1);
    check("idle_tx", get_tx(w), 1);
    check("idle_busy", get_busy(w), 0);
    build_frame(d, p, (w != 0) ? 1 : 4, (w != 0) ? 2 : 1);
    drive(w, 1'b1, d, p);
    @(negedge clk);
    drive(w, keep, nd, np);
    len = exp_q.size();
    for (int k = 0; k < len; k++) begin
      e = exp_q.pop_front();
      check("frame_tx", get_tx(w), e);
      check("frame_busy", get_busy(w), 1);
      check("frame_ready", get_ready(w), 0);
      check("frame_done", get_fd(w), (k == len - 1) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [6:0] d, d2;
    logic       p, p2;

    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_ready_a", if_a.data_ready, 1);
    check("rst_fd_a", fd_a, 0);
    check("rst_state_a", st_a, ST_IDLE);
    check("rst_tx_b", tx_b, 1);
    check("rst_ready_b", if_b.data_ready, 1);
    @(negedge clk);

    // 0x55 with parity 0 at 4 clk/bit: alternating line, done at cycle 40
    run_frame(0, 7'h55, 1'b0, 1'b0, 7'h00, 1'b0);
    check("post_55_ready", if_a.data_ready, 1);
    check("post_55_tx", tx_a, 1);

    // back-to-back 0x7F/1 then 0x00/0 with one idle cycle in between
    run_frame(0, 7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1);
    run_frame(0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0);

    // data changes mid-frame: 0x2D unaffected, 0x12 goes next
    run_frame(0, 7'h2D, 1'b1, 1'b1, 7'h12, 1'b0);
    run_frame(0, 7'h12, 1'b0, 1'b0, 7'h00, 1'b0);

    // 1 clk/bit, 2 stop bits: 0,1,0,0,0,0,0,0,1,1,1
    run_frame(1, 7'h01, 1'b1, 1'b0, 7'h00, 1'b0);

    // random frames on both instances, some back-to-back, random junk offered mid-frame
    for (int i = 0; i < 6; i++) begin
      d  = 7'($urandom_range(0, 127));
      p  = 1'($urandom_range(0, 1));
      d2 = 7'($urandom_range(0, 127));
      p2 = 1'($urandom_range(0, 1));
      run_frame(0, d, p, 1'b1, d2, p2);
      run_frame(0, d2, p2, 1'b0, 7'($urandom_range(0, 127)), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      d  = 7'($urandom_range(0, 127));
      p  = 1'($urandom_range(0, 1));
      d2 = 7'($urandom_range(0, 127));
      p2 = 1'($urandom_range(0, 1));
      run_frame(1, d, p, 1'b1, d2, p2);
      run_frame(1, d2, p2, 1'b0, 7'($urandom_range(0, 127)), 1'b1);
    end

    // reset during data bit 3 (cycles 17..20 of the frame)
    d = 7'($urandom_range(0, 127)) ^ 7'h08;
    drive(0, 1'b1, d, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 7'h00, 1'b0);
    repeat (17) @(negedge clk);
    check("bit3_tx", tx_a, d[3]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_ready", if_a.data_ready, 1);
    check("midrst_fd", fd_a, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("midrst_idle_tx", tx_a, 1);
      check("midrst_no_fd", fd_a, 0);
    end

    // reset and offer on the same edge: nothing sent
    rst = 1'b1;
    drive(0, 1'b1, 7'h2A, 1'b1);
    drive(1, 1'b1, 7'h2A, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 7'h00, 1'b0);
    drive(1, 1'b0, 7'h00, 1'b0);
    check("rstacc_busy_a", busy_a, 0);
    check("rstacc_busy_b", busy_b, 0);
    for (int c = 0; c < 20; c++) begin
      check("rstacc_tx_a", tx_a, 1);
      check("rstacc_tx_b", tx_b, 1);
      @(negedge clk);
    end

    // still usable afterwards
    run_frame(0, 7'h3C, 1'b0, 1'b0, 7'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
